// File: rtl/waveform_to_pipe_pkg.sv
// Shared widths, limits and write-FSM encoding for the waveform-to-pipe
// transmit path.
package waveform_to_pipe_pkg;
    localparam int WORD_W   = 16;
    localparam int SAMPLE_W = 32;
    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wr_state_e;
endpackage

// File: rtl/pipe_out_fifo.sv
// Word FIFO feeding the BTPipeOut endpoint: simple dual-port RAM with a
// registered read port, wrapping pointers and an occupancy counter.
module pipe_out_fifo
    import waveform_to_pipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [WORD_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    output logic [WORD_W-1:0]     rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DEPTH_LOG2:0]   count_next_o,
    output logic                  empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  empty, do_wr, do_rd, clear;

    assign clear = reset_i | flush_i;
    assign empty = (count_q == '0);
    assign do_wr = wr_en_i & ~clear;
    assign do_rd = rd_en_i & ~empty & ~clear;

    always_comb begin
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
        if (clear) count_d = '0;
    end

    // RAM array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (!flush_i && rd_en_i) begin
            rd_data_q <= empty ? '0 : mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign empty_o      = empty;
endmodule

// File: rtl/waveform_to_pipe.sv
// Captures one 32-bit simulation value per slow test_clk period and streams
// it to the host as low/high 16-bit words through the BTPipeOut handshake.
module waveform_to_pipe
    import waveform_to_pipe_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  ti_clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  test_clk,
    input  logic                  capture_en,
    input  logic [SAMPLE_W-1:0]   sample_data,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [WORD_W-1:0]     ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   words_avail,
    output logic [15:0]           overflow_cnt,
    output logic                  underflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic                unused_blockstrobe;
    logic [2:0]          sync_q;
    logic                tick, cap_tick, space_ok;
    wr_state_e           state_q, state_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                ovf_inc;
    logic                ep_ready_q, underflow_q;
    logic                wr_en;
    logic [WORD_W-1:0]   wr_data;
    logic [CW-1:0]       count, count_next;
    logic                empty;

    assign unused_blockstrobe = ep_blockstrobe;

    // Two synchronizer stages plus one history flop for rising-edge detect.
    assign tick     = sync_q[1] & ~sync_q[2];
    assign cap_tick = tick & capture_en;
    // Both words of a sample are reserved at admission time.
    assign space_ok = (count <= CW'(DEPTH - 2));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ovf_inc = 1'b0;
        wr_en   = 1'b0;
        wr_data = hold_q[WORD_W-1:0];
        case (state_q)
            IDLE: begin
                if (cap_tick) begin
                    if (space_ok) begin
                        hold_d  = sample_data;
                        state_d = WR_LO;
                    end else begin
                        ovf_inc = 1'b1;
                    end
                end
            end
            WR_LO: begin
                wr_en   = 1'b1;
                wr_data = hold_q[WORD_W-1:0];
                state_d = WR_HI;
                ovf_inc = cap_tick;
            end
            WR_HI: begin
                wr_en   = 1'b1;
                wr_data = hold_q[SAMPLE_W-1:WORD_W];
                state_d = IDLE;
                ovf_inc = cap_tick;
            end
            default: state_d = IDLE;
        endcase
        ovf_d = (ovf_inc && ovf_q != OVF_MAX) ? ovf_q + 16'd1 : ovf_q;
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            ovf_q       <= '0;
            ep_ready_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            sync_q     <= {sync_q[1:0], test_clk};
            state_q    <= IDLE;
            ep_ready_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], test_clk};
            state_q    <= state_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            ep_ready_q <= (count_next >= CW'(BLOCK_WORDS));
            if (ep_read && empty) underflow_q <= 1'b1;
        end
    end

    pipe_out_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i        (ti_clk),
        .reset_i      (reset),
        .flush_i      (flush),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .rd_en_i      (ep_read),
        .rd_data_o    (ep_datain),
        .count_o      (count),
        .count_next_o (count_next),
        .empty_o      (empty)
    );

    assign ep_ready     = ep_ready_q;
    assign words_avail  = count;
    assign overflow_cnt = ovf_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_waveform_to_pipe.sv
// Scoreboard bench for waveform_to_pipe: a word-queue model predicts every
// read, a monitor compares ep_datain on the cycle after each ep_read.
module tb_waveform_to_pipe;
    localparam int DL    = 10;
    localparam int BW    = 256;
    localparam int DEPTH = 1 << DL;

    logic        ti_clk, reset, flush, test_clk, capture_en, ep_read, ep_blockstrobe;
    logic [31:0] sample_data;
    logic [15:0] ep_datain, overflow_cnt;
    logic        ep_ready, underflow;
    logic [DL:0] words_avail;

    waveform_to_pipe #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
        .ti_clk(ti_clk), .reset(reset), .flush(flush), .test_clk(test_clk),
        .capture_en(capture_en), .sample_data(sample_data), .ep_read(ep_read),
        .ep_blockstrobe(ep_blockstrobe), .ep_datain(ep_datain), .ep_ready(ep_ready),
        .words_avail(words_avail), .overflow_cnt(overflow_cnt), .underflow(underflow)
    );

    initial ti_clk = 1'b0;
    always #5 ti_clk = ~ti_clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_q[$];
    logic [15:0] exp_q[$];
    int model_ovf = 0;
    logic model_uf = 1'b0;
    logic rd_seen;
    logic [15:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge ti_clk) rd_seen <= ep_read && !reset && !flush;

    always @(negedge ti_clk) begin
        if (rd_seen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no read", ep_datain);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", {16'h0, ep_datain}, {16'h0, mon_exp});
            end
        end
    end

    // One test_clk high pulse; model admits a sample if two words fit.
    task automatic sample(input logic [31:0] d, input int hold);
        @(negedge ti_clk);
        sample_data = d;
        test_clk = 1'b1;
        if (capture_en) begin
            if (model_q.size() <= DEPTH - 2) begin
                model_q.push_back(d[15:0]);
                model_q.push_back(d[31:16]);
            end else if (model_ovf < 65535) begin
                model_ovf++;
            end
        end
        repeat (hold) @(negedge ti_clk);
        test_clk = 1'b0;
        repeat (4) @(negedge ti_clk);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ti_clk);
            ep_read = 1'b1;
            if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
            else begin
                exp_q.push_back(16'h0000);
                model_uf = 1'b1;
            end
        end
        @(negedge ti_clk);
        ep_read = 1'b0;
    endtask

    // Start a sample and abort it with reset or flush during the WR_LO cycle.
    task automatic abort_wr_lo(input bit use_reset);
        @(negedge ti_clk);
        sample_data = $urandom;
        test_clk = 1'b1;
        repeat (3) @(negedge ti_clk);
        test_clk = 1'b0;
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(negedge ti_clk);
        reset = 1'b0;
        flush = 1'b0;
        model_q.delete();
        if (use_reset) begin
            model_ovf = 0;
            model_uf = 1'b0;
        end
        check(use_reset ? "abort_rst_avail" : "abort_flush_avail", words_avail, 0);
        check(use_reset ? "abort_rst_ovf" : "abort_flush_ovf", overflow_cnt, model_ovf);
        @(negedge ti_clk);
        check(use_reset ? "abort_rst_nowrite" : "abort_flush_nowrite", words_avail, 0);
        check(use_reset ? "abort_rst_ready" : "abort_flush_ready", ep_ready, 0);
        repeat (4) @(negedge ti_clk);
        check(use_reset ? "abort_rst_quiet" : "abort_flush_quiet", words_avail, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; test_clk = 1'b0; capture_en = 1'b0;
        ep_read = 1'b0; ep_blockstrobe = 1'b0; sample_data = '0;
        repeat (3) @(negedge ti_clk);
        check("rst_datain", ep_datain, 0);
        check("rst_ready", ep_ready, 0);
        check("rst_avail", words_avail, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_underflow", underflow, 0);
        reset = 1'b0;

        // One full block of known samples.
        capture_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            sample(32'h3F80_0000 + i, 3);
            if (i == 126) check("ready_below_block", ep_ready, 0);
        end
        check("block_avail", words_avail, 256);
        check("block_ready", ep_ready, 1);
        rd(256);
        check("drain_avail", words_avail, 0);
        check("drain_ready", ep_ready, 0);

        // Read from empty FIFO.
        rd(1);
        check("uf_flag", underflow, 1);
        check("uf_avail", words_avail, 0);
        sample($urandom, 3);
        check("uf_capture", words_avail, 2);
        rd(2);
        check("uf_sticky", underflow, 1);

        // Fill boundaries: 1022 admits, 1023 and 1024 drop.
        for (int i = 0; i < 511; i++) sample($urandom, 3);
        check("fill_1022", words_avail, 1022);
        sample($urandom, 3);
        check("fill_1024", words_avail, 1024);
        check("fill_no_ovf", overflow_cnt, 0);
        sample($urandom, 3);
        check("full_drop_avail", words_avail, 1024);
        check("full_drop_ovf", overflow_cnt, 1);
        rd(1);
        sample($urandom, 3);
        check("drop_1023_avail", words_avail, 1023);
        check("drop_1023_ovf", overflow_cnt, model_ovf);
        rd(1023);
        check("fill_drained", words_avail, 0);

        // Read coinciding with the WR_LO write at 300 words.
        for (int i = 0; i < 150; i++) sample($urandom, 3);
        check("steady_300", words_avail, 300);
        @(negedge ti_clk);
        sample_data = $urandom;
        test_clk = 1'b1;
        model_q.push_back(sample_data[15:0]);
        model_q.push_back(sample_data[31:16]);
        repeat (3) @(negedge ti_clk);
        test_clk = 1'b0;
        ep_read = 1'b1;
        exp_q.push_back(model_q.pop_front());
        @(negedge ti_clk);
        ep_read = 1'b0;
        check("concurrent_avail", words_avail, 300);
        @(negedge ti_clk);
        check("concurrent_hi", words_avail, 301);
        repeat (3) @(negedge ti_clk);
        rd(301);
        check("concurrent_drained", words_avail, 0);

        // Abort a pending write with flush, then with reset.
        sample($urandom, 3);
        abort_wr_lo(1'b0);
        check("flush_uf_kept", underflow, 1);
        sample($urandom, 3);
        abort_wr_lo(1'b1);
        check("rst_uf_clear", underflow, 0);

        // Long high level gives one sample; disabled capture gives none.
        capture_en = 1'b1;
        sample($urandom, 50);
        check("long_high", words_avail, 2);
        capture_en = 1'b0;
        for (int i = 0; i < 10; i++) sample($urandom, 3);
        check("cap_off_avail", words_avail, 2);
        check("cap_off_ovf", overflow_cnt, 0);
        rd(2);

        // Random interleave of samples and read bursts.
        capture_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) sample($urandom, 3 + $urandom_range(0, 5));
            else rd($urandom_range(1, 6));
        end
        check("rand_avail", words_avail, model_q.size());
        check("rand_ovf", overflow_cnt, model_ovf);
        check("rand_uf", underflow, model_uf);
        rd(model_q.size());
        check("rand_drained", words_avail, 0);

        repeat (3) @(negedge ti_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
